encode_mul_pipe: RTL and testbench

Parametrised, multi-lane pipelined multiplier with valid/ready flow control for the encoder datapath. Each lane computes signed din0 × unsigned din1, then applies a fixed-point rescale with an arithmetic right shift, round-half-up and optional saturation to the output width. It supersedes the fixed two-stage, ce-only multiplier cores. It sits between the encoder MAC/scale stages, which need back-pressure and lane-parallel products.

---
 rtl/encode_mul_pkg.sv | 49 ++++
 rtl/encode_mul_lane.sv | 98 +++++++++
 rtl/encode_mul_pipe.sv | 89 ++++++++
 tb/tb_encode_mul_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/encode_mul_pkg.sv
// ============================================================================
// Module  : encode_mul_pkg
// Brief   : Shared constants and the rescale/saturate helper for encode_mul_pipe
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package encode_mul_pkg;

    localparam int SAT_CNT_W       = 16;
    localparam int DEF_DIN0_WIDTH  = 40;
    localparam int DEF_DIN1_WIDTH  = 31;
    localparam int DEF_DOUT_WIDTH  = 32;
    // Working widths of the helper; products up to MAX_PW-1 bits are exact
    localparam int MAX_PW          = 128;
    localparam int MAX_DW          = 64;

    // Returns {flag, value}; value holds the low MAX_DW bits of the result
    function automatic logic [MAX_DW:0] rescale_sat(
        input logic signed [MAX_PW-1:0] p,
        input int                       shift,
        input int                       dw,
        input bit                       sat
    );
        logic signed [MAX_PW:0] one;
        logic signed [MAX_PW:0] rnd;
        logic signed [MAX_PW:0] r;
        logic signed [MAX_PW:0] hi;
        logic signed [MAX_PW:0] lo;
        logic [MAX_DW:0]        res;
        one = {{MAX_PW{1'b0}}, 1'b1};
        rnd = (shift > 0) ? (one <<< (shift - 1)) : '0;
        r   = ($signed({p[MAX_PW-1], p}) + rnd) >>> shift;
        hi  = (one <<< (dw - 1)) - one;
        lo  = ~hi;
        res = {1'b0, r[MAX_DW-1:0]};
        if (sat) begin
            if (r > hi) begin
                res = {1'b1, hi[MAX_DW-1:0]};
            end else if (r < lo) begin
                res = {1'b1, lo[MAX_DW-1:0]};
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/encode_mul_lane.sv
// ============================================================================
// Module  : encode_mul_lane
// Brief   : One lane: operand register, product stages, rescaled result register
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module encode_mul_lane
    import encode_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
    parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int NUM_STAGE  = 2,
    parameter int SHIFT      = 0,
    parameter int SAT        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_adv,
    input  logic [DIN0_WIDTH-1:0] i_a,
    input  logic [DIN1_WIDTH-1:0] i_b,
    output logic [DOUT_WIDTH-1:0] o_dout,
    output logic                  o_flag
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

    logic signed [PW-1:0] w_ae;
    logic signed [PW-1:0] w_be;
    logic signed [PW-1:0] w_p0;
    logic signed [PW-1:0] w_prod;
    logic [MAX_DW:0]      w_res;
    logic                 w_unused_res;
    logic [DOUT_WIDTH-1:0] r_dout;
    logic                 r_flag;

    // A single-stage pipe multiplies straight from the ports into the result register
    if (NUM_STAGE == 1) begin : g_no_opreg
        assign w_ae = {{DIN1_WIDTH{i_a[DIN0_WIDTH-1]}}, i_a};
        assign w_be = {{DIN0_WIDTH{1'b0}}, i_b};
    end else begin : g_opreg
        logic [DIN0_WIDTH-1:0] r_a;
        logic [DIN1_WIDTH-1:0] r_b;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_a <= '0;
                r_b <= '0;
            end else if (i_adv) begin
                r_a <= i_a;
                r_b <= i_b;
            end
        end
        assign w_ae = {{DIN1_WIDTH{r_a[DIN0_WIDTH-1]}}, r_a};
        assign w_be = {{DIN0_WIDTH{1'b0}}, r_b};
    end

    assign w_p0 = w_ae * w_be;

    if (NUM_STAGE <= 2) begin : g_no_mid
        assign w_prod = w_p0;
    end else begin : g_mid
        logic signed [PW-1:0] r_mid [NUM_STAGE-2];
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < NUM_STAGE - 2; i++) begin
                    r_mid[i] <= '0;
                end
            end else if (i_adv) begin
                r_mid[0] <= w_p0;
                for (int i = 1; i < NUM_STAGE - 2; i++) begin
                    r_mid[i] <= r_mid[i-1];
                end
            end
        end
        assign w_prod = r_mid[NUM_STAGE-3];
    end

    assign w_res        = rescale_sat({{(MAX_PW-PW){w_prod[PW-1]}}, w_prod},
                                      SHIFT, DOUT_WIDTH, SAT != 0);
    assign w_unused_res = ^w_res;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout <= '0;
            r_flag <= 1'b0;
        end else if (i_adv) begin
            r_dout <= w_res[DOUT_WIDTH-1:0];
            r_flag <= w_res[MAX_DW];
        end
    end

    assign o_dout = r_dout;
    assign o_flag = r_flag;

endmodule

`default_nettype wire

// File: rtl/encode_mul_pipe.sv
// ============================================================================
// Module  : encode_mul_pipe
// Brief   : Multi-lane signed x unsigned multiplier with rescale, valid/ready
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module encode_mul_pipe
    import encode_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
    parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int LANES      = 1,
    parameter int NUM_STAGE  = 2,
    parameter int SHIFT      = 0,
    parameter int SAT        = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DIN0_WIDTH-1:0] din0,
    input  logic [LANES*DIN1_WIDTH-1:0] din1,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DOUT_WIDTH-1:0] dout,
    output logic [LANES-1:0]            sat_flag,
    output logic [SAT_CNT_W-1:0]        sat_count,
    input  logic                        clr_count
);

    logic [NUM_STAGE-1:0] r_vld;
    logic [SAT_CNT_W-1:0] r_sat_cnt;
    logic                 w_adv;
    logic                 w_deliver;

    // The whole pipe moves as one; a held output blocks every stage behind it
    assign w_adv     = ce && (!r_vld[NUM_STAGE-1] || out_ready);
    assign w_deliver = ce && r_vld[NUM_STAGE-1] && out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[NUM_STAGE-1];
    assign sat_count = r_sat_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            for (int i = 1; i < NUM_STAGE; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        encode_mul_lane #(
            .DIN0_WIDTH (DIN0_WIDTH),
            .DIN1_WIDTH (DIN1_WIDTH),
            .DOUT_WIDTH (DOUT_WIDTH),
            .NUM_STAGE  (NUM_STAGE),
            .SHIFT      (SHIFT),
            .SAT        (SAT)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .i_adv  (w_adv),
            .i_a    (din0[g*DIN0_WIDTH +: DIN0_WIDTH]),
            .i_b    (din1[g*DIN1_WIDTH +: DIN1_WIDTH]),
            .o_dout (dout[g*DOUT_WIDTH +: DOUT_WIDTH]),
            .o_flag (sat_flag[g])
        );
    end

    // Clear wins over a same-cycle increment and does not wait for ce
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat_cnt <= '0;
        end else if (clr_count) begin
            r_sat_cnt <= '0;
        end else if (w_deliver && (|sat_flag) && (r_sat_cnt != {SAT_CNT_W{1'b1}})) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_encode_mul_pipe.sv
// ============================================================================
// Module  : tb_encode_mul_pipe
// Brief   : Four 8-bit, 4-lane configurations driven in parallel against a model
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_encode_mul_pipe;

    localparam int ND = 4;
    localparam int NS_P  [ND] = '{2, 3, 4, 1};
    localparam int SH_P  [ND] = '{0, 4, 4, 3};
    localparam int SAT_P [ND] = '{1, 1, 0, 1};

    logic        clk;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        out_ready;
    logic        clr_count;
    logic [31:0] din0;
    logic [31:0] din1;

    logic        ov     [ND];
    logic        ir     [ND];
    logic [31:0] dout_a [ND];
    logic [3:0]  sf     [ND];
    logic [15:0] sc     [ND];

    int total;
    int bad;

    // Model: in-flight beats per configuration with the advances each has seen
    logic [35:0] mq   [ND][8];
    int          age  [ND][8];
    int          hd   [ND];
    int          cntq [ND];
    int          mcnt [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        encode_mul_pipe #(
            .DIN0_WIDTH (8),
            .DIN1_WIDTH (8),
            .DOUT_WIDTH (8),
            .LANES      (4),
            .NUM_STAGE  (NS_P[g]),
            .SHIFT      (SH_P[g]),
            .SAT        (SAT_P[g])
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .ce        (ce),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .din0      (din0),
            .din1      (din1),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .dout      (dout_a[g]),
            .sat_flag  (sf[g]),
            .sat_count (sc[g]),
            .clr_count (clr_count)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {flag, 8-bit result} straight from the arithmetic definition
    function automatic logic [8:0] lane_exp(input int a, input int b, input int sh, input int sat);
        longint     p;
        longint     r;
        logic [8:0] e;
        p = longint'(a) * longint'(b);
        r = p + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0));
        r = r >>> sh;
        e = {1'b0, r[7:0]};
        if (sat != 0 && r > 127) e = 9'h07F | 9'h100;
        else if (sat != 0 && r < -128) e = 9'h180;
        return e;
    endfunction

    function automatic logic [35:0] beat_exp(input int k, input logic [31:0] a, input logic [31:0] b);
        logic [35:0]       e;
        logic signed [7:0] as;
        logic [8:0]        l;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            as = a[i*8 +: 8];
            l  = lane_exp(int'(as), int'(b[i*8 +: 8]), SH_P[k], SAT_P[k]);
            e[i*8 +: 8] = l[7:0];
            e[32+i]     = l[8];
        end
        return e;
    endfunction

    task automatic cmp(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d actual=%h required=%h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic        exp_ov;
        logic        adv;
        logic [35:0] h;
        for (int k = 0; k < ND; k++) begin
            if (!reset) begin
                cntq[k] = 0;
                mcnt[k] = 0;
                cmp(k, "rst_out_valid", 32'(ov[k]), 32'd0);
                cmp(k, "rst_dout", dout_a[k], 32'd0);
                cmp(k, "rst_sat_flag", 32'(sf[k]), 32'd0);
                cmp(k, "rst_sat_count", 32'(sc[k]), 32'd0);
            end else begin
                exp_ov = (cntq[k] > 0) && (age[k][hd[k]] == NS_P[k] - 1);
                adv    = ce && (!exp_ov || out_ready);
                h      = mq[k][hd[k]];
                cmp(k, "out_valid", 32'(ov[k]), 32'(exp_ov));
                cmp(k, "in_ready", 32'(ir[k]), 32'(adv));
                cmp(k, "sat_count", 32'(sc[k]), 32'(mcnt[k]));
                if (exp_ov) begin
                    cmp(k, "dout", dout_a[k], h[31:0]);
                    cmp(k, "sat_flag", 32'(sf[k]), 32'(h[35:32]));
                end
                if (clr_count) mcnt[k] = 0;
                else if (adv && exp_ov && (|h[35:32]) && mcnt[k] < 65535) mcnt[k]++;
                if (adv) begin
                    if (exp_ov) begin
                        hd[k]   = (hd[k] + 1) % 8;
                        cntq[k] = cntq[k] - 1;
                    end
                    for (int i = 0; i < cntq[k]; i++) age[k][(hd[k] + i) % 8]++;
                    if (in_valid) begin
                        mq[k][(hd[k] + cntq[k]) % 8]  = beat_exp(k, din0, din1);
                        age[k][(hd[k] + cntq[k]) % 8] = 0;
                        cntq[k]++;
                    end
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int k = 0; k < ND; k++) begin
            hd[k] = 0; cntq[k] = 0; mcnt[k] = 0;
        end
        reset = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        clr_count = 1'b0; din0 = '0; din1 = '0;

        // Hand-computed anchors for the model
        cmp(-1, "pin_3x5",         32'(lane_exp(3, 5, 0, 1)),       32'h00F);
        cmp(-1, "pin_m4x200_sat",  32'(lane_exp(-4, 200, 0, 1)),    32'h180);
        cmp(-1, "pin_1x8_sh4",     32'(lane_exp(1, 8, 4, 1)),       32'h001);
        cmp(-1, "pin_m1x8_sh4",    32'(lane_exp(-1, 8, 4, 1)),      32'h000);
        cmp(-1, "pin_m1x24_sh4",   32'(lane_exp(-1, 24, 4, 1)),     32'h0FF);
        cmp(-1, "pin_min_sat",     32'(lane_exp(-128, 255, 4, 1)),  32'h180);
        cmp(-1, "pin_min_wrap",    32'(lane_exp(-128, 255, 4, 0)),  32'h008);

        repeat (3) begin
            @(negedge clk); #1; check_all();
        end
        @(negedge clk); reset = 1'b1; #1; check_all();

        // Directed beats carrying the anchor operands in all four lanes
        @(negedge clk);
        in_valid = 1'b1;
        din0 = {8'hFF, 8'h01, 8'hFC, 8'h03}; din1 = {8'd8, 8'd8, 8'd200, 8'd5};
        #1; check_all();
        @(negedge clk);
        din0 = {8'h7F, 8'h00, 8'h80, 8'hFF}; din1 = {8'd255, 8'd0, 8'd255, 8'd24};
        #1; check_all();
        @(negedge clk); in_valid = 1'b0; #1; check_all();
        repeat (6) begin
            @(negedge clk); #1; check_all();
        end

        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 9) < 7);
            din0      = ($urandom_range(0, 3) == 0) ? 32'h80FF7F80 : $urandom;
            din1      = ($urandom_range(0, 3) == 0) ? 32'hFFFF01FF : $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            ce        = ($urandom_range(0, 19) != 0);
            clr_count = ($urandom_range(0, 19) == 0);
            if (cyc >= 200 && cyc < 205) ce = 1'b0;
            reset = !(cyc >= 400 && cyc < 402);
            #1; check_all();
        end

        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; ce = 1'b1; clr_count = 1'b0; reset = 1'b1;
        #1; check_all();
        repeat (10) begin
            @(negedge clk); #1; check_all();
        end
        for (int k = 0; k < ND; k++) begin
            cmp(k, "drain_empty", 32'(cntq[k]), 32'd0);
            cmp(k, "drain_out_valid", 32'(ov[k]), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
